// File: rtl/id_inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: default geometry and
// the layout of a packed queue entry {exc, addr, inst}.
package id_inst_queue_pkg;

    localparam int unsigned IQ_DEPTH      = 4;
    localparam int unsigned IQ_ADDR_WIDTH = 32;
    localparam int unsigned IQ_INST_WIDTH = 32;
    localparam int unsigned IQ_DATA_WIDTH = IQ_ADDR_WIDTH + IQ_INST_WIDTH + 1;

    // Field positions of a packed entry for the default geometry.
    localparam int unsigned IQ_INST_LSB = 0;
    localparam int unsigned IQ_ADDR_LSB = IQ_INST_WIDTH;
    localparam int unsigned IQ_EXC_BIT  = IQ_ADDR_WIDTH + IQ_INST_WIDTH;

    function automatic int unsigned iq_entry_width(input int unsigned aw, input int unsigned iw);
        return aw + iw + 1;
    endfunction

endpackage

// File: rtl/id_queue_mem.sv
// Entry storage for the instruction queue: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module id_queue_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: circular buffer with delay-slot tagging,
// branch flush that keeps the head, and full exception flush.
module id_inst_queue
    import id_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = IQ_DEPTH,
    parameter int unsigned ADDR_WIDTH = IQ_ADDR_WIDTH,
    parameter int unsigned INST_WIDTH = IQ_INST_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [INST_WIDTH-1:0]      in_inst,
    input  logic                       in_exc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [INST_WIDTH-1:0]      out_inst,
    output logic                       out_exc,
    output logic                       out_delayslot,
    input  logic                       id_branch,
    input  logic                       flush,
    input  logic                       flush_keep_head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned DATA_W  = iq_entry_width(ADDR_WIDTH, INST_WIDTH);
    localparam int unsigned ADDR_LO = INST_WIDTH;
    localparam int unsigned EXC_BIT = ADDR_WIDTH + INST_WIDTH;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              ds_pending;
    logic              enq;
    logic              deq;
    logic [DATA_W-1:0] wr_entry;
    logic [DATA_W-1:0] rd_entry;

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign enq       = in_valid & in_ready & ~flush;
    assign deq       = out_valid & out_ready;

    assign wr_entry      = {in_exc, in_addr, in_inst};
    assign out_inst      = rd_entry[INST_WIDTH-1:0];
    assign out_addr      = rd_entry[ADDR_LO +: ADDR_WIDTH];
    assign out_exc       = rd_entry[EXC_BIT];
    assign out_delayslot = ds_pending;

    id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (enq & ~rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ds_pending <= 1'b0;
        end else begin
            if (flush && !flush_keep_head) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else if (flush) begin
                // Branch flush: keep only the head (the delay slot) if it survives this cycle.
                if (deq) begin
                    count  <= '0;
                    rd_ptr <= rd_ptr + ONE_PTR;
                    wr_ptr <= rd_ptr + ONE_PTR;
                end else if (out_valid) begin
                    count  <= ONE_CNT;
                    wr_ptr <= rd_ptr + ONE_PTR;
                end
            end else begin
                count  <= count + CNT_W'(enq) - CNT_W'(deq);
                rd_ptr <= rd_ptr + PTR_W'(deq);
                wr_ptr <= wr_ptr + PTR_W'(enq);
            end

            // A same-cycle branch wins over the dequeue clear.
            if (flush && !flush_keep_head) begin
                ds_pending <= 1'b0;
            end else if (id_branch) begin
                ds_pending <= 1'b1;
            end else if (deq) begin
                ds_pending <= 1'b0;
            end
        end
    end

endmodule
